// File: rtl/fifo_rd_drainer_if.sv
// FIFO read-side and downstream stream signals of the drainer.
// The master modport is the drainer. The slave modport is the FIFO plus the sink.
interface fifo_rd_drainer_if #(
  parameter int FIFO_WIDTH = 16
);
  logic                  rd_en;
  logic                  empty;
  logic                  underflow;
  logic [FIFO_WIDTH-1:0] data_out;
  logic [FIFO_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output rd_en, m_data, m_valid,
    input  empty, underflow, data_out, m_ready
  );

  modport slave (
    input  rd_en, m_data, m_valid,
    output empty, underflow, data_out, m_ready
  );
endinterface

// File: rtl/fifo_rd_drainer.sv
// Read-side drainer for the synchronous FIFO.
// It issues rd_en only when a buffer slot is guaranteed for the word once it
// lands one cycle later. Words are re-presented on a valid/ready stream through
// a 2-entry skid buffer.
module fifo_rd_drainer #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 clear,
  fifo_rd_drainer_if.master    bus,
  output logic [CNT_WIDTH-1:0] rd_count,
  output logic                 underflow_err
);

  logic [FIFO_WIDTH-1:0] mem [2];
  logic                  head;
  logic                  tail;
  logic [1:0]            buf_cnt;
  logic                  rd_pend;
  logic                  pop;
  logic [2:0]            occ_nxt;

  assign pop         = bus.m_valid && bus.m_ready;
  assign bus.m_valid = (buf_cnt != 2'd0);
  assign bus.m_data  = mem[head];

  // Occupancy after this edge, counting the in-flight word and excluding a word
  // that leaves this cycle. A new read is allowed only while that is below 2.
  // The read then always lands in a free slot.
  assign occ_nxt   = {1'b0, buf_cnt} + {2'b0, rd_pend} - {2'b0, pop};
  assign bus.rd_en = rst_n && enable && !bus.empty && (occ_nxt < 3'd2);

  // Skid buffer: the landing word is pushed at the tail, and a pop advances the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      head    <= 1'b0;
      tail    <= 1'b0;
      buf_cnt <= 2'd0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= bus.rd_en;
      if (rd_pend) begin
        mem[tail] <= bus.data_out;
        tail      <= ~tail;
      end
      if (pop) head <= ~head;
      buf_cnt <= buf_cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Delivered-word counter and sticky underflow flag. Clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else if (clear) begin
      rd_count      <= '0;
      underflow_err <= 1'b0;
    end else begin
      if (pop)           rd_count      <= rd_count + 1'b1;
      if (bus.underflow) underflow_err <= 1'b1;
    end
  end

endmodule
